// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the gate_tester BIST stage.
// Truth-table bit index is {drv_x, drv_y}.
package gate_tester_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int VEC_COUNT = 4;

   localparam logic [3:0] TT_AND   = 4'b1000;
   localparam logic [3:0] TT_NAND  = 4'b0111;
   localparam logic [3:0] TT_OR    = 4'b1110;
   localparam logic [3:0] TT_NOR   = 4'b0001;
   localparam logic [3:0] TT_XOR   = 4'b0110;
   localparam logic [3:0] TT_INV_X = 4'b0011;

   // Set bits mark input vectors where the cell disagreed with the reference.
   function automatic logic [3:0] tt_mismatch(input logic [3:0] obs, input logic [3:0] ref_tt);
      return obs ^ ref_tt;
   endfunction

endpackage

// File: rtl/gate_tester_settle_timer.sv
// 4-bit settle counter: counts while enabled, wraps to zero on terminal count.
// tc_o is high whenever the count equals term_i.
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [3:0] term_i,
   output logic       tc_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   assign tc_o = (cnt_q == term_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (en_i) begin
         cnt_d = tc_o ? 4'd0 : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_tester.sv
// Drives a two-input cell through 00,01,10,11, samples its output after a settle window,
// and reports the captured truth table with pass/fail flags and a done pulse.
module gate_tester
   import gate_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECT_TT     = TT_AND
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       gate_out,
   output logic       drv_x,
   output logic       drv_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [3:0] obs_tt
);

   generate
      if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("gate_tester: SETTLE_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] TERM = 4'(SETTLE_CYCLES - 1);

   state_e     state_q;
   logic [1:0] idx_q;
   logic [1:0] idx_inc;
   logic       drv_x_q, drv_y_q, busy_q, done_q, pass_q;
   logic [3:0] fail_vec_q, obs_tt_q;
   logic [3:0] obs_tt_d;
   logic       settle_tc;

   settle_timer u_settle (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (state_q == IDLE && start),
      .en_i   (state_q == DRIVE),
      .term_i (TERM),
      .tc_o   (settle_tc)
   );

   // Unsampled bits are still zero from the start clear, so OR-ing in the new sample is enough.
   assign obs_tt_d = obs_tt_q | (4'(gate_out) << idx_q);
   assign idx_inc  = idx_q + 2'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         drv_x_q    <= 1'b0;
         drv_y_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_vec_q <= 4'd0;
         obs_tt_q   <= 4'd0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= DRIVE;
                  idx_q      <= 2'd0;
                  drv_x_q    <= 1'b0;
                  drv_y_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  obs_tt_q   <= 4'd0;
                  pass_q     <= 1'b0;
                  fail_vec_q <= 4'd0;
               end
            end
            DRIVE: begin
               if (settle_tc) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               obs_tt_q <= obs_tt_d;
               if (idx_q == 2'(VEC_COUNT - 1)) begin
                  state_q    <= DONE;
                  idx_q      <= 2'd0;
                  drv_x_q    <= 1'b0;
                  drv_y_q    <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  pass_q     <= (obs_tt_d == EXPECT_TT);
                  fail_vec_q <= tt_mismatch(obs_tt_d, EXPECT_TT);
               end else begin
                  state_q <= DRIVE;
                  idx_q   <= idx_inc;
                  drv_x_q <= idx_inc[1];
                  drv_y_q <= idx_inc[0];
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign drv_x    = drv_x_q;
   assign drv_y    = drv_y_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign fail_vec = fail_vec_q;
   assign obs_tt   = obs_tt_q;

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: three instances (AND ref, NAND ref, fast settle)
// driven by behavioural cell models; a monitor per instance checks each done pulse.
module tb_gate_tester;
   import gate_tester_pkg::*;

   typedef struct {
      int         done_cyc;
      logic [3:0] obs;
      logic       pass;
      logic [3:0] fv;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start, gate_out, drv_x, drv_y, busy, done, pass;
   logic [3:0] fail_vec [3];
   logic [3:0] obs_tt [3];
   int         mode [3];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;
   exp_t       q0[$], q1[$], q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 0: AND cell, 1: output stuck at 0, 2: NAND cell
   function automatic logic model(input int m, input logic x, input logic y);
      case (m)
         0:       return x & y;
         2:       return ~(x & y);
         default: return 1'b0;
      endcase
   endfunction

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cell
         assign gate_out[gi] = model(mode[gi], drv_x[gi], drv_y[gi]);
      end
   endgenerate

   gate_tester #(.SETTLE_CYCLES(2), .EXPECT_TT(TT_AND)) u_and (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_out(gate_out[0]),
      .drv_x(drv_x[0]), .drv_y(drv_y[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .fail_vec(fail_vec[0]), .obs_tt(obs_tt[0]));

   gate_tester #(.SETTLE_CYCLES(2), .EXPECT_TT(TT_NAND)) u_nand (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_out(gate_out[1]),
      .drv_x(drv_x[1]), .drv_y(drv_y[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .fail_vec(fail_vec[1]), .obs_tt(obs_tt[1]));

   gate_tester #(.SETTLE_CYCLES(1), .EXPECT_TT(TT_AND)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .gate_out(gate_out[2]),
      .drv_x(drv_x[2]), .drv_y(drv_y[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .fail_vec(fail_vec[2]), .obs_tt(obs_tt[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
      end
   endtask

   task automatic push(input int inst, input exp_t e);
      case (inst)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic check_done(input int inst, input exp_t e);
      $display("[TB] inst %0d done at cycle %0d obs_tt=%b pass=%b fail_vec=%b",
               inst, cyc, obs_tt[inst], pass[inst], fail_vec[inst]);
      chk("done_cycle", cyc, e.done_cyc);
      chk("obs_tt", obs_tt[inst], e.obs);
      chk("pass", pass[inst], e.pass);
      chk("fail_vec", fail_vec[inst], e.fv);
      chk("busy_at_done", busy[inst], 0);
   endtask

   task automatic unexpected(input int inst);
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_done inst %0d at cycle %0d: got done=1 required done=0", inst, cyc);
   endtask

   always @(negedge clk) if (done[0] === 1'b1) begin
      if (q0.size() == 0) unexpected(0); else check_done(0, q0.pop_front());
   end
   always @(negedge clk) if (done[1] === 1'b1) begin
      if (q1.size() == 0) unexpected(1); else check_done(1, q1.pop_front());
   end
   always @(negedge clk) if (done[2] === 1'b1) begin
      if (q2.size() == 0) unexpected(2); else check_done(2, q2.pop_front());
   end

   // Pulses start for one cycle; returns at the negedge of the accept cycle.
   task automatic launch(input int inst, input int m, input logic [3:0] o, input logic p,
                         input logic [3:0] fv, input int lat, input bit expect_done);
      exp_t e;
      @(negedge clk);
      mode[inst]  = m;
      start[inst] = 1'b1;
      e.done_cyc  = cyc + 1 + lat;
      e.obs       = o;
      e.pass      = p;
      e.fv        = fv;
      if (expect_done) push(inst, e);
      @(negedge clk);
      start[inst] = 1'b0;
   endtask

   task automatic check_drv(input int inst, input int s);
      for (int j = 0; j < 4 * (s + 1); j++) begin
         chk("drv_vec", {drv_x[inst], drv_y[inst]}, j / (s + 1));
         chk("busy_run", busy[inst], 1);
         @(negedge clk);
      end
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      chk("pending_results", q0.size() + q1.size() + q2.size(), 0);
   endtask

   task automatic check_zero(input int inst);
      chk("zero_outputs", {drv_x[inst], drv_y[inst], busy[inst], done[inst], pass[inst],
                           fail_vec[inst], obs_tt[inst]}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by cycle %0d required finish", cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   a;
      int   low;
      exp_t e;
      rst_n = 1'b0;
      start = 3'b000;
      for (int i = 0; i < 3; i++) mode[i] = 0;
      repeat (2) @(negedge clk);
      check_zero(0);
      check_zero(2);
      rst_n = 1'b1;

      // AND cell against AND reference, with vector sequence check
      launch(0, 0, 4'b1000, 1'b1, 4'b0000, 12, 1'b1);
      check_drv(0, 2);
      drain(4);
      chk("pass_held", pass[0], 1);

      // stuck-at-0 output
      launch(0, 1, 4'b0000, 1'b0, 4'b1000, 12, 1'b1);
      drain(16);
      chk("fail_vec_held", fail_vec[0], 4'b1000);

      // NAND cell against AND reference, then against NAND reference
      launch(0, 2, 4'b0111, 1'b0, 4'b1111, 12, 1'b1);
      drain(16);
      launch(1, 2, 4'b0111, 1'b1, 4'b0000, 12, 1'b1);
      drain(16);

      // start pulses during a run are ignored
      launch(0, 0, 4'b1000, 1'b1, 4'b0000, 12, 1'b1);
      repeat (3) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      drain(16);

      // reset mid-run aborts with no done, then a fresh run passes
      launch(0, 0, 4'b1000, 1'b1, 4'b0000, 12, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero(0);
      rst_n = 1'b1;
      drain(16);
      launch(0, 0, 4'b1000, 1'b1, 4'b0000, 12, 1'b1);
      drain(16);

      // single-cycle settle
      launch(2, 0, 4'b1000, 1'b1, 4'b0000, 8, 1'b1);
      check_drv(2, 1);
      drain(4);

      // start held high: back-to-back runs every 14 cycles (DONE + one IDLE between)
      @(negedge clk);
      mode[0]  = 0;
      start[0] = 1'b1;
      a = cyc + 1;
      e.obs = 4'b1000;
      e.pass = 1'b1;
      e.fv = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         e.done_cyc = a + 12 + 14 * k;
         push(0, e);
      end
      low = 0;
      for (int k = 0; k < 41; k++) begin
         @(negedge clk);
         if (cyc >= a + 12 && cyc <= a + 25 && busy[0] == 1'b0) low++;
      end
      start[0] = 1'b0;
      chk("busy_gap_cycles", low, 2);
      drain(16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
